// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Stall/flush sequencer for a 5-stage RISC-V pipeline.
//                Priority: data-memory wait (freeze) > taken branch (flush)
//                > load-use (one-cycle stall). Saturating stall/flush
//                performance counters and a sticky memory-timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_mem_read_i,
    input  logic [4:0]       idex_rd_i,
    input  logic [4:0]       ifid_rs1_i,
    input  logic [4:0]       ifid_rs2_i,
    input  logic             ifid_use_rs2_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             idex_write_o,
    output logic             exmem_write_o,
    output logic             memwb_bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_err_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [8:0] TIMEOUT_VAL  = 9'(MEM_TIMEOUT);

    state_t           state, state_nxt;
    state_t           saved_state, saved_state_nxt;
    logic [2:0]       flush_cnt, flush_cnt_nxt;
    logic [7:0]       wait_cnt, wait_cnt_nxt;
    logic             mem_err_nxt;
    logic             branch_accept;
    logic [CNT_W-1:0] stall_cnt, flush_total;

    // Hazard detection
    logic   mem_wait;
    logic   load_use;
    state_t eff_state;
    logic [8:0] wait_inc;

    assign mem_wait = dmem_req_i & ~dmem_ready_i;
    assign load_use = idex_mem_read_i && (idex_rd_i != 5'd0) &&
                      ((idex_rd_i == ifid_rs1_i) ||
                       (ifid_use_rs2_i && (idex_rd_i == ifid_rs2_i)));
    // Leaving a memory wait resumes whatever was in progress before it
    assign eff_state = (state == ST_MEM_WAIT) ? saved_state : state;
    assign wait_inc  = {1'b0, wait_cnt} + 9'd1;

    // Next-state and same-cycle pipeline controls
    always_comb begin
        pc_write_o      = 1'b1;
        ifid_write_o    = 1'b1;
        ifid_flush_o    = 1'b0;
        idex_bubble_o   = 1'b0;
        idex_write_o    = 1'b1;
        exmem_write_o   = 1'b1;
        memwb_bubble_o  = 1'b0;
        state_nxt       = state;
        saved_state_nxt = saved_state;
        flush_cnt_nxt   = flush_cnt;
        wait_cnt_nxt    = 8'd0;
        mem_err_nxt     = mem_err_o;
        branch_accept   = 1'b0;

        if (rst_i) begin
            pc_write_o      = 1'b0;
            ifid_write_o    = 1'b0;
            ifid_flush_o    = 1'b1;
            idex_bubble_o   = 1'b1;
            memwb_bubble_o  = 1'b1;
            state_nxt       = ST_RUN;
            saved_state_nxt = ST_RUN;
            flush_cnt_nxt   = 3'd0;
            mem_err_nxt     = 1'b0;
        end else if (mem_wait) begin
            // Freeze everything; the flush counter and saved state hold
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_write_o   = 1'b0;
            exmem_write_o  = 1'b0;
            memwb_bubble_o = 1'b1;
            state_nxt      = ST_MEM_WAIT;
            if (state != ST_MEM_WAIT) begin
                saved_state_nxt = state;
            end
            wait_cnt_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_inc[7:0];
            if (wait_inc >= TIMEOUT_VAL) begin
                mem_err_nxt = 1'b1;
            end
        end else if (branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            branch_accept = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt     = ST_FLUSH;
                flush_cnt_nxt = FLUSH_RELOAD;
            end else begin
                state_nxt     = ST_RUN;
                flush_cnt_nxt = 3'd0;
            end
        end else if (eff_state == ST_FLUSH) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            if (flush_cnt <= 3'd1) begin
                state_nxt     = ST_RUN;
                flush_cnt_nxt = 3'd0;
            end else begin
                state_nxt     = ST_FLUSH;
                flush_cnt_nxt = flush_cnt - 3'd1;
            end
        end else begin
            state_nxt = ST_RUN;
            if (load_use) begin
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
                idex_bubble_o = 1'b1;
            end
        end
    end

    // State, sequencing counters and sticky error flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_RUN;
            saved_state <= ST_RUN;
            flush_cnt   <= 3'd0;
            wait_cnt    <= 8'd0;
            mem_err_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            saved_state <= saved_state_nxt;
            flush_cnt   <= flush_cnt_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_err_o   <= mem_err_nxt;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt   <= '0;
            flush_total <= '0;
        end else begin
            if (!pc_write_o && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (branch_accept && (flush_total != '1)) begin
                flush_total <= flush_total + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_total;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Scoreboard bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3,
//                MEM_TIMEOUT=8). A reference model predicts each cycle's
//                controls and counters; predictions are queued on drive and
//                popped on the following falling edge for comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int FLUSH_CYCLES = 3;
    localparam int MEM_TIMEOUT  = 8;
    localparam int CNT_W        = 16;

    logic clk = 1'b0;
    logic rst, mr, use2, br, req, rdy;
    logic [4:0] rd, rs1, rs2;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, exmem_write, memwb_bubble;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic mem_err;

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .idex_mem_read_i(mr),
        .idex_rd_i      (rd),
        .ifid_rs1_i     (rs1),
        .ifid_rs2_i     (rs2),
        .ifid_use_rs2_i (use2),
        .branch_taken_i (br),
        .dmem_req_i     (req),
        .dmem_ready_i   (rdy),
        .pc_write_o     (pc_write),
        .ifid_write_o   (ifid_write),
        .ifid_flush_o   (ifid_flush),
        .idex_bubble_o  (idex_bubble),
        .idex_write_o   (idex_write),
        .exmem_write_o  (exmem_write),
        .memwb_bubble_o (memwb_bubble),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt),
        .mem_err_o      (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] ctl;
        int         stall;
        int         flush;
        logic       err;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state (0=RUN, 1=FLUSH, 2=MEM_WAIT)
    int   m_state = 0, m_saved = 0, m_fc = 0, m_wc = 0, m_stall = 0, m_flush = 0;
    logic m_err = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle, predict it, then compare and advance the model
    task automatic cycle(input string tag, input logic i_rst, input logic i_mr,
                         input logic [4:0] i_rd, input logic [4:0] i_rs1,
                         input logic [4:0] i_rs2, input logic i_use2,
                         input logic i_br, input logic i_req, input logic i_rdy);
        exp_t e, got;
        int   ns, nsaved, nfc, nwc, nstall, nflush, eff;
        logic nerr, lu;
        rst = i_rst; mr = i_mr; rd = i_rd; rs1 = i_rs1; rs2 = i_rs2;
        use2 = i_use2; br = i_br; req = i_req; rdy = i_rdy;

        e.stall = m_stall; e.flush = m_flush; e.err = m_err; e.tag = tag;
        ns = m_state; nsaved = m_saved; nfc = m_fc; nwc = 0;
        nstall = m_stall; nflush = m_flush; nerr = m_err;
        eff = (m_state == 2) ? m_saved : m_state;
        lu  = i_mr && (i_rd != 0) && ((i_rd == i_rs1) || (i_use2 && (i_rd == i_rs2)));
        // ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, exmem_write, memwb_bubble}
        if (i_rst) begin
            e.ctl = 7'b0011111;
            ns = 0; nsaved = 0; nfc = 0; nstall = 0; nflush = 0; nerr = 1'b0;
        end else begin
            if (i_req && !i_rdy) begin
                e.ctl = 7'b0000001;
                if (m_state != 2) nsaved = m_state;
                ns  = 2;
                nwc = (m_wc < 255) ? m_wc + 1 : 255;
                if (m_wc + 1 >= MEM_TIMEOUT) nerr = 1'b1;
            end else if (i_br) begin
                e.ctl = 7'b1111110;
                nflush = m_flush + 1;
                ns = 1; nfc = FLUSH_CYCLES - 1;
            end else if (eff == 1) begin
                e.ctl = 7'b1111110;
                if (m_fc <= 1) begin ns = 0; nfc = 0; end
                else begin ns = 1; nfc = m_fc - 1; end
            end else begin
                ns = 0;
                e.ctl = lu ? 7'b0001110 : 7'b1100110;
            end
            if (!e.ctl[6]) nstall = m_stall + 1;
        end
        exp_q.push_back(e);

        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_value("queue_empty", 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check_value({got.tag, "/ctl"},
                        {25'd0, pc_write, ifid_write, ifid_flush, idex_bubble,
                         idex_write, exmem_write, memwb_bubble}, {25'd0, got.ctl});
            check_value({got.tag, "/stall_cnt"}, {16'd0, stall_cnt}, got.stall);
            check_value({got.tag, "/flush_cnt"}, {16'd0, flush_cnt}, got.flush);
            check_value({got.tag, "/mem_err"}, {31'd0, mem_err}, {31'd0, got.err});
        end

        @(posedge clk);
        m_state = ns; m_saved = nsaved; m_fc = nfc; m_wc = nwc;
        m_stall = nstall; m_flush = nflush; m_err = nerr;
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; mr = 0; rd = 0; rs1 = 0; rs2 = 0; use2 = 0; br = 0; req = 0; rdy = 0;
        @(posedge clk); #1;

        // Reset, then reset applied mid-flush
        cycle("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("idle", 2);
        cycle("br_pre_rst", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle("flush2", 1);
        for (int i = 0; i < 3; i++) cycle("rst_mid_flush", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("post_rst", 2);

        // Load-use cases
        cycle("lu_rs1",   0, 1, 5, 5, 0, 0, 0, 0, 0);
        cycle("lu_clear", 0, 0, 0, 5, 0, 0, 0, 0, 0);
        cycle("lu_rd0",   0, 1, 0, 0, 0, 1, 0, 0, 0);
        cycle("lu_rs2_nouse", 0, 1, 7, 1, 7, 0, 0, 0, 0);
        cycle("lu_rs2_use",   0, 1, 7, 1, 7, 1, 0, 0, 0);
        idle("idle", 1);

        // Branch flush, re-trigger in flush cycle 2
        cycle("br1", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle("flush", 3);
        cycle("br2", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle("br3_retrig", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle("flush", 4);

        // Branch together with a load-use match
        cycle("br_lu", 0, 1, 3, 3, 0, 0, 1, 0, 0);
        idle("flush", 3);

        // Memory freeze with a branch held throughout
        for (int i = 0; i < 4; i++) cycle("mwait_br", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cycle("mready_br", 0, 0, 0, 0, 0, 0, 1, 1, 1);
        idle("flush", 3);

        // Memory wait in the middle of a flush
        cycle("br_fw", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) cycle("mwait_fl", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle("mready_fl", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle("flush", 3);

        // Timeout
        for (int i = 0; i < 10; i++) cycle("timeout", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle("timeout_rdy", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle("err_sticky", 2);
        cycle("err_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("err_clear", 1);

        // Mixed random traffic
        for (int i = 0; i < 60; i++) begin
            cycle("rand", ($urandom_range(0, 39) == 0), 1'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                  1'($urandom));
        end

        if (exp_q.size() != 0) check_value("queue_drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives write-enable, flush and bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazard classes with a fixed priority: data-memory wait (freeze), taken-branch (flush), load-use (one-cycle stall).
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles ifid_flush_o is asserted per taken branch (range 1..7).
- MEM_TIMEOUT, 64, consecutive MEM_WAIT cycles after which mem_err_o sets (range 2..255).
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  input  1  clock, all state updates on posedge.
- rst_i  input  1  synchronous, active-high reset.
- idex_mem_read_i  input  1  the instruction in EX is a load.
- idex_rd_i  input  5  destination register of the instruction in EX.
- ifid_rs1_i  input  5  rs1 of the instruction in ID.
- ifid_rs2_i  input  5  rs2 of the instruction in ID.
- ifid_use_rs2_i  input  1  the instruction in ID reads rs2.
- branch_taken_i  input  1  branch/jump resolved taken this cycle.
- dmem_req_i  input  1  MEM stage is accessing data memory.
- dmem_ready_i  input  1  data memory completes the access this cycle.
- pc_write_o  output  1  PC register load enable.
- ifid_write_o  output  1  IF/ID write enable.
- ifid_flush_o  output  1  IF/ID clear (takes precedence over write).
- idex_bubble_o  output  1  force ID/EX control field to 0.
- idex_write_o  output  1  ID/EX write enable.
- exmem_write_o  output  1  EX/MEM write enable.
- memwb_bubble_o  output  1  force MEM/WB control field to 0.
- stall_cnt_o  output  CNT_W  cycles with pc_write_o=0, saturating.
- flush_cnt_o  output  CNT_W  accepted taken branches, saturating.
- mem_err_o  output  1  sticky memory-timeout flag.

Behaviour:
- States: RUN, FLUSH, MEM_WAIT. Registered state, 3-bit flush counter, 8-bit wait counter.
- Outputs are combinational from state and current inputs (same-cycle response, zero latency). Counters and state update on posedge.
- Reset (rst_i=1): state goes to RUN, all counters go to 0, mem_err_o=0. While rst_i=1, outputs are forced to: pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1, idex_write_o=1, exmem_write_o=1, memwb_bubble_o=1. A reset asserted mid-stall or mid-flush aborts the operation immediately.
- Default outputs (no hazard): pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, idex_write=1, exmem_write=1, memwb_bubble=0.
- Priority 1, memory wait. Condition: dmem_req_i=1 and dmem_ready_i=0, in any state.
  - Outputs: pc_write=0, ifid_write=0, idex_write=0, exmem_write=0, memwb_bubble=1, ifid_flush=0, idex_bubble=0.
  - Next state is MEM_WAIT. The state and flush counter saved from before the wait are preserved.
  - branch_taken_i and load-use detection are ignored during the wait; the frozen registers re-present them afterwards.
  - Each MEM_WAIT cycle increments the wait counter. When the count reaches MEM_TIMEOUT, mem_err_o sets and stays set until reset.
  - Cycle with dmem_ready_i=1: the wait counter clears and the state returns to the saved state (RUN or FLUSH). Normal evaluation applies in that same cycle.
- Priority 2, taken branch. Condition: branch_taken_i=1 and no memory wait.
  - Outputs: ifid_flush=1, idex_bubble=1, pc_write=1.
  - flush_cnt_o increments.
  - If FLUSH_CYCLES>1: next state is FLUSH with the counter loaded to FLUSH_CYCLES-1.
  - A taken branch arriving while in FLUSH reloads the counter.
  - Load-use is suppressed in this cycle (the ID instruction is squashed).
- FLUSH state: ifid_flush=1, idex_bubble=1, pc_write=1. The counter decrements each cycle; at 0 the next state is RUN.
- Priority 3, load-use. Only evaluated in RUN with no branch and no memory wait.
  - Condition: idex_mem_read_i=1 and idex_rd_i!=0 and (idex_rd_i==ifid_rs1_i or (ifid_use_rs2_i and idex_rd_i==ifid_rs2_i)).
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - No state change. The condition self-clears next cycle once the bubble is in EX.
- Counters saturate at all-ones and never wrap. stall_cnt_o increments in every non-reset cycle with pc_write_o=0.

Test Plan:
- Reset, then rst_i held for 3 cycles mid-FLUSH -> outputs hold reset values; after release: RUN, counters 0, default outputs.
- Load-use: idex_mem_read_i=1, idex_rd_i=5, ifid_rs1_i=5 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt_o=1. Repeat with idex_rd_i=0, or rs2 match with ifid_use_rs2_i=0 -> no stall.
- FLUSH_CYCLES=3, one-cycle branch_taken_i pulse -> ifid_flush=1 for exactly 3 cycles; flush_cnt_o=1. A second pulse in flush cycle 2 -> 3 further flush cycles, flush_cnt_o=2.
- Simultaneous branch_taken_i and load-use match -> flush only, pc_write=1, stall_cnt_o unchanged.
- dmem_req_i=1 with dmem_ready_i=0 for 4 cycles, then ready -> 4 freeze cycles (all writes 0, memwb_bubble=1), stall_cnt_o=4. A branch_taken_i held during the freeze is acted on in the ready cycle.
- MEM_TIMEOUT=8, ready withheld for 10 cycles -> mem_err_o rises after the 8th wait cycle and stays 1 after ready, until rst_i.
